// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register plus operand selection for the 64-bit execute ALU.
// It latches the decoded instruction fields, builds the final ALU operands and
// the store data, and covers hazards:
//   - EX/MEM and MEM/WB forwarding into both source operands
//   - load-use bubble insertion with an ID stall
//   - downstream hold (freeze) and branch/jump flush (kill)
//
// Build option: define FORWARDING_EN to get the forwarding muxes and the
// load-use detector. When it is undefined there are no forwarding muxes.
// Instead, any RAW dependence on this stage or on EX/MEM inserts bubbles
// until the producer reaches the write-first register file.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   id_*                  decoded instruction fields from the ID stage
//   exm_*                 EX/MEM destination and result (forwarding source)
//   mwb_*                 MEM/WB destination and writeback value
//   ex_hold               downstream stall, freezes this stage
//   ex_flush              redirect, kills the contents of this stage
//   stall_id              freezes PC and IF/ID this cycle
//   alu_a, alu_b          final ALU operands
//   alu_op                registered ALU operation code
//   alu_work_on_word      registered W-form flag
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd_addr, ex_pc
//                         registered control and PC
//   ex_store_data         forwarded rs2 value, used by stores
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_alu_src_a,
  input  logic            id_alu_src_b,
  input  logic [3:0]      id_alu_op,
  input  logic            id_word,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_rd_addr,
  input  logic [XLEN-1:0] mwb_data,
  input  logic            ex_hold,
  input  logic            ex_flush,
  output logic            stall_id,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic            alu_work_on_word,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data
);

  // Latched fields that are not outputs themselves
  logic [RA_W-1:0] ex_rs1_addr;
  logic [RA_W-1:0] ex_rs2_addr;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic            ex_src_a;
  logic            ex_src_b;

  logic            hazard;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

`ifdef FORWARDING_EN
  // Only a load in EX can't be forwarded in time, so only that dependence
  // costs a bubble.
  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_rd_addr != '0) & id_valid &
             ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
              (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
  end

  // EX/MEM is the younger producer and must win over MEM/WB. x0 is never
  // forwarded because its architectural value is always zero.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (exm_reg_write && (exm_rd_addr != '0) && (exm_rd_addr == ex_rs1_addr))
      fwd_rs1 = exm_result;
    else if (mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == ex_rs1_addr))
      fwd_rs1 = mwb_data;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (exm_reg_write && (exm_rd_addr != '0) && (exm_rd_addr == ex_rs2_addr))
      fwd_rs2 = exm_result;
    else if (mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == ex_rs2_addr))
      fwd_rs2 = mwb_data;
  end
`else
  logic raw_rs1;
  logic raw_rs2;
  logic unused_fwd_inputs;

  // No forwarding: a source written by this stage or by EX/MEM is not yet
  // visible in the register file. MEM/WB is covered by the write-first read.
  always_comb begin
    raw_rs1 = id_uses_rs1 & (id_rs1_addr != '0) &
              ((ex_valid & ex_reg_write & (id_rs1_addr == ex_rd_addr)) |
               (exm_reg_write & (id_rs1_addr == exm_rd_addr)));
    raw_rs2 = id_uses_rs2 & (id_rs2_addr != '0) &
              ((ex_valid & ex_reg_write & (id_rs2_addr == ex_rd_addr)) |
               (exm_reg_write & (id_rs2_addr == exm_rd_addr)));
    hazard  = id_valid & (raw_rs1 | raw_rs2);
  end

  always_comb begin
    fwd_rs1 = ex_rs1_data;
    fwd_rs2 = ex_rs2_data;
  end

  assign unused_fwd_inputs = ^{exm_result, mwb_reg_write, mwb_rd_addr,
                               mwb_data, ex_rs1_addr, ex_rs2_addr};
`endif

  // A flush wins over everything: the redirected stream must not be stalled
  assign stall_id = (hazard | ex_hold) & ~ex_flush;

  // Pipeline register: reset/flush and hazard load a side-effect-free
  // bubble, hold keeps the current instruction, otherwise take the ID fields.
  always_ff @(posedge clk) begin
    if (rst || ex_flush || (!ex_hold && hazard)) begin
      ex_valid         <= 1'b0;
      ex_reg_write     <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_rd_addr       <= '0;
      ex_pc            <= '0;
      ex_rs1_addr      <= '0;
      ex_rs2_addr      <= '0;
      ex_rs1_data      <= '0;
      ex_rs2_data      <= '0;
      ex_imm           <= '0;
      ex_src_a         <= 1'b0;
      ex_src_b         <= 1'b0;
      alu_op           <= 4'b0000;
      alu_work_on_word <= 1'b0;
    end else if (!ex_hold) begin
      ex_valid         <= id_valid;
      ex_reg_write     <= id_reg_write;
      ex_mem_read      <= id_mem_read;
      ex_mem_write     <= id_mem_write;
      ex_rd_addr       <= id_rd_addr;
      ex_pc            <= id_pc;
      ex_rs1_addr      <= id_rs1_addr;
      ex_rs2_addr      <= id_rs2_addr;
      ex_rs1_data      <= id_rs1_data;
      ex_rs2_data      <= id_rs2_data;
      ex_imm           <= id_imm;
      ex_src_a         <= id_alu_src_a;
      ex_src_b         <= id_alu_src_b;
      alu_op           <= id_alu_op;
      alu_work_on_word <= id_word;
    end
  end

  // Operand select
  always_comb begin
    alu_a         = ex_src_a ? ex_pc : fwd_rs1;
    alu_b         = ex_src_b ? ex_imm : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Self-checking bench for id_ex_operand_stage. A behavioural model tracks the
// instruction held in the stage. Every cycle, the outputs are compared with
// what the model says they must be. Directed sequences with literal
// expectations come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_uses_rs1, id_uses_rs2;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd_addr;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        id_alu_src_a, id_alu_src_b;
  logic [3:0]  id_alu_op;
  logic        id_word;
  logic        exm_reg_write;
  logic [4:0]  exm_rd_addr;
  logic [63:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd_addr;
  logic [63:0] mwb_data;
  logic        ex_hold, ex_flush;

  logic        stall_id;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_work_on_word;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd_addr;
  logic [63:0] ex_pc, ex_store_data;

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
    .id_alu_op(id_alu_op), .id_word(id_word),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
    .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr),
    .mwb_data(mwb_data),
    .ex_hold(ex_hold), .ex_flush(ex_flush),
    .stall_id(stall_id), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_work_on_word(alu_work_on_word),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd_addr(ex_rd_addr), .ex_pc(ex_pc), .ex_store_data(ex_store_data)
  );

  // Model of the instruction currently sitting in the EX stage
  typedef struct {
    logic        valid, rw, mr, mw, sa, sb, word;
    logic [4:0]  rd, rs1, rs2;
    logic [3:0]  op;
    logic [63:0] pc, d1, d2, imm;
  } ex_instr_t;

  ex_instr_t m;
  ex_instr_t bubble;

  // Whether the instruction in ID must wait this cycle
  function automatic logic model_hazard();
`ifdef FORWARDING_EN
    if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 1'b0;
    return (id_uses_rs1 && id_rs1_addr == m.rd) ||
           (id_uses_rs2 && id_rs2_addr == m.rd);
`else
    logic dep;
    dep = 1'b0;
    if (id_uses_rs1 && id_rs1_addr != 0 &&
        ((m.valid && m.rw && id_rs1_addr == m.rd) ||
         (exm_reg_write && id_rs1_addr == exm_rd_addr))) dep = 1'b1;
    if (id_uses_rs2 && id_rs2_addr != 0 &&
        ((m.valid && m.rw && id_rs2_addr == m.rd) ||
         (exm_reg_write && id_rs2_addr == exm_rd_addr))) dep = 1'b1;
    return id_valid && dep;
`endif
  endfunction

  // Value of a source register seen in EX
  function automatic logic [63:0] model_src(input logic [4:0] a, input logic [63:0] latched);
`ifdef FORWARDING_EN
    if (a != 0 && exm_reg_write && exm_rd_addr == a) return exm_result;
    if (a != 0 && mwb_reg_write && mwb_rd_addr == a) return mwb_data;
`endif
    return latched;
  endfunction

  task automatic model_step();
    ex_instr_t n;
    n = m;
    if (rst || ex_flush) n = bubble;
    else if (ex_hold) n = m;
    else if (model_hazard()) n = bubble;
    else begin
      n.valid = id_valid; n.rw = id_reg_write; n.mr = id_mem_read;
      n.mw = id_mem_write; n.sa = id_alu_src_a; n.sb = id_alu_src_b;
      n.word = id_word; n.rd = id_rd_addr; n.rs1 = id_rs1_addr;
      n.rs2 = id_rs2_addr; n.op = id_alu_op; n.pc = id_pc;
      n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
    end
    m = n;
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act !== exp)
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    else
      checks_passed++;
  endtask

  // Full comparison of every output against the model
  task automatic checkOutput();
    logic [63:0] s1, s2;
    s1 = model_src(m.rs1, m.d1);
    s2 = model_src(m.rs2, m.d2);
    check_val("stall_id", {63'd0, stall_id}, {63'd0, (model_hazard() || ex_hold) && !ex_flush});
    check_val("alu_a", alu_a, m.sa ? m.pc : s1);
    check_val("alu_b", alu_b, m.sb ? m.imm : s2);
    check_val("ex_store_data", ex_store_data, s2);
    check_val("alu_op", {60'd0, alu_op}, {60'd0, m.op});
    check_val("alu_work_on_word", {63'd0, alu_work_on_word}, {63'd0, m.word});
    check_val("ex_valid", {63'd0, ex_valid}, {63'd0, m.valid});
    check_val("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m.rw});
    check_val("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m.mr});
    check_val("ex_mem_write", {63'd0, ex_mem_write}, {63'd0, m.mw});
    check_val("ex_rd_addr", {59'd0, ex_rd_addr}, {59'd0, m.rd});
    check_val("ex_pc", ex_pc, m.pc);
  endtask

  // Called at a negedge with inputs already driven
  task automatic tick();
    #1;
    checkOutput();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_rd_addr = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_alu_src_a = 1'b0; id_alu_src_b = 1'b0; id_alu_op = '0; id_word = 1'b0;
    exm_reg_write = 1'b0; exm_rd_addr = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd_addr = '0; mwb_data = '0;
    ex_hold = 1'b0; ex_flush = 1'b0;
  endtask

  task automatic set_id(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic [3:0] op);
    id_valid = 1'b1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = 64'h40; id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = 1'b0; id_alu_src_a = 1'b0; id_alu_src_b = 1'b0;
    id_alu_op = op; id_word = 1'b0;
  endtask

  // Randomized traffic; small register range to provoke dependences
  task automatic applyStimulus();
    rst = ($urandom_range(0, 49) == 0);
    id_valid = ($urandom_range(0, 9) != 0);
    id_pc = {$urandom, $urandom};
    id_rs1_addr = 5'($urandom_range(0, 3));
    id_rs2_addr = 5'($urandom_range(0, 3));
    id_uses_rs1 = $urandom_range(0, 1) == 1;
    id_uses_rs2 = $urandom_range(0, 1) == 1;
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm = {$urandom, $urandom};
    id_rd_addr = 5'($urandom_range(0, 3));
    id_reg_write = $urandom_range(0, 1) == 1;
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = ($urandom_range(0, 4) == 0);
    id_alu_src_a = $urandom_range(0, 1) == 1;
    id_alu_src_b = $urandom_range(0, 1) == 1;
    id_alu_op = 4'($urandom_range(0, 15));
    id_word = $urandom_range(0, 1) == 1;
    exm_reg_write = $urandom_range(0, 1) == 1;
    exm_rd_addr = 5'($urandom_range(0, 3));
    exm_result = {$urandom, $urandom};
    mwb_reg_write = $urandom_range(0, 1) == 1;
    mwb_rd_addr = 5'($urandom_range(0, 3));
    mwb_data = {$urandom, $urandom};
    ex_hold = ($urandom_range(0, 6) == 0);
    ex_flush = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    bubble = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, sa: 1'b0, sb: 1'b0,
               word: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, op: 4'd0,
               pc: 64'd0, d1: 64'd0, d2: 64'd0, imm: 64'd0};
    m = bubble;

    // Reset held two cycles while ID offers a real instruction
    set_idle();
    rst = 1'b1;
    set_id(64'h100, 5'd1, 5'd2, 1'b1, 1'b1, 64'h1, 64'h2, 5'd3, 1'b1, 1'b0, 4'd7);
    @(negedge clk);
    tick();
    #1;
    check_val("reset ex_valid", {63'd0, ex_valid}, 64'd0);
    check_val("reset ex_reg_write", {63'd0, ex_reg_write}, 64'd0);
    check_val("reset alu_op", {60'd0, alu_op}, 64'd0);
    check_val("reset stall_id", {63'd0, stall_id}, 64'd0);
    set_idle();
    tick();

    // Hold for three cycles, then hold together with flush
    set_id(64'h1234, 5'd1, 5'd2, 1'b0, 1'b0, 64'h1, 64'h2, 5'd9, 1'b1, 1'b0, 4'd5);
    tick();
    set_id(64'h5678, 5'd1, 5'd2, 1'b0, 1'b0, 64'h1, 64'h2, 5'd4, 1'b1, 1'b0, 4'd2);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("hold ex_pc", ex_pc, 64'h1234);
      check_val("hold alu_op", {60'd0, alu_op}, 64'd5);
      check_val("hold ex_rd_addr", {59'd0, ex_rd_addr}, 64'd9);
      check_val("hold stall_id", {63'd0, stall_id}, 64'd1);
      tick();
    end
    ex_flush = 1'b1;
    #1;
    check_val("hold+flush stall_id", {63'd0, stall_id}, 64'd0);
    tick();
    set_idle();
    #1;
    check_val("flush ex_valid", {63'd0, ex_valid}, 64'd0);
    tick();

`ifdef FORWARDING_EN
    // EX/MEM forwarding, and its priority over MEM/WB
    set_id(64'h200, 5'd3, 5'd0, 1'b1, 1'b0, 64'h5, 64'h0, 5'd6, 1'b1, 1'b0, 4'd0);
    tick();
    set_idle();
    exm_reg_write = 1'b1; exm_rd_addr = 5'd3; exm_result = 64'h10;
    #1;
    check_val("fwd exm alu_a", alu_a, 64'h10);
    mwb_reg_write = 1'b1; mwb_rd_addr = 5'd3; mwb_data = 64'h20;
    #1;
    check_val("fwd exm over mwb alu_a", alu_a, 64'h10);
    ex_hold = 1'b1;
    tick();
    set_idle();
    tick();

    // x0 is never forwarded
    set_id(64'h300, 5'd0, 5'd0, 1'b1, 1'b0, 64'h0, 64'h0, 5'd1, 1'b1, 1'b0, 4'd0);
    tick();
    set_idle();
    exm_reg_write = 1'b1; exm_rd_addr = 5'd0; exm_result = 64'hFF;
    #1;
    check_val("x0 alu_a", alu_a, 64'h0);
    tick();

    // Load-use: one bubble, then EX/MEM forwarding of the loaded value
    set_id(64'h400, 5'd1, 5'd0, 1'b1, 1'b0, 64'h0, 64'h0, 5'd5, 1'b1, 1'b1, 4'd0);
    tick();
    set_id(64'h404, 5'd0, 5'd5, 1'b0, 1'b1, 64'h0, 64'h99, 5'd8, 1'b0, 1'b0, 4'd0);
    #1;
    check_val("load-use stall_id", {63'd0, stall_id}, 64'd1);
    tick();
    exm_reg_write = 1'b1; exm_rd_addr = 5'd5; exm_result = 64'hABC;
    #1;
    check_val("load-use bubble", {63'd0, ex_valid}, 64'd0);
    check_val("load-use release", {63'd0, stall_id}, 64'd0);
    tick();
    #1;
    check_val("load-use fwd store", ex_store_data, 64'hABC);
    check_val("load-use pc", ex_pc, 64'h404);
    set_idle();
    tick();
`else
    // ADDI x7 in EX, ID reads x7: two bubbles, then regfile data is used
    set_id(64'h500, 5'd1, 5'd0, 1'b1, 1'b0, 64'h0, 64'h0, 5'd7, 1'b1, 1'b0, 4'd0);
    tick();
    set_id(64'h504, 5'd7, 5'd0, 1'b1, 1'b0, 64'h77, 64'h0, 5'd8, 1'b1, 1'b0, 4'd0);
    #1;
    check_val("raw stall 1", {63'd0, stall_id}, 64'd1);
    tick();
    exm_reg_write = 1'b1; exm_rd_addr = 5'd7; exm_result = 64'hDEAD;
    #1;
    check_val("raw stall 2", {63'd0, stall_id}, 64'd1);
    check_val("raw bubble 1", {63'd0, ex_valid}, 64'd0);
    tick();
    exm_reg_write = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd_addr = 5'd7; mwb_data = 64'h77;
    #1;
    check_val("raw release", {63'd0, stall_id}, 64'd0);
    check_val("raw bubble 2", {63'd0, ex_valid}, 64'd0);
    tick();
    set_idle();
    #1;
    check_val("raw loaded valid", {63'd0, ex_valid}, 64'd1);
    check_val("raw loaded alu_a", alu_a, 64'h77);
    tick();
`endif

    for (int c = 0; c < 800; c++) begin
      applyStimulus();
      tick();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
